// File: rtl/ip_result_collector.sv
// ip_result_collector: buffers JPEG IP result words in a small FIFO
// and writes them in order to consecutive data-memory word addresses.
module ip_result_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic [31:0]       ip_data,
  input  logic              ip_valid,
  output logic              ip_ready,
  input  logic              mem_stall,
  output logic              mem_ena,
  output logic              mem_rw,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [15:0] CNT_ONE = 16'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       cnt_q;
  logic [15:0]       rx_cnt;
  logic [15:0]       wr_cnt;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;

  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  logic empty;
  logic full;
  logic active;
  logic hs;
  logic pop;
  logic wr_done;
  logic arm;
  logic last_rx;
  logic last_wr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign active  = (state_q == COLLECT) ||
                   (state_q == DRAIN);
  assign ip_ready = (state_q == COLLECT) && !full;
  assign hs      = ip_valid && ip_ready;
  assign pop     = active && !empty && !mem_stall;
  assign wr_done = wen_q && !mem_stall;
  assign arm     = (state_q == IDLE) && start;
  assign last_rx = hs && ((rx_cnt + CNT_ONE) == cnt_q);
  assign last_wr = (wr_cnt == cnt_q) && wr_done;

  assign mem_ena   = wen_q;
  assign mem_rw    = wen_q;
  assign mem_addr  = 32'(waddr_q);
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Next-state selection for the collection run
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == 16'd0) state_d = DONE;
          else                     state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (last_rx) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_wr) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the run parameters captured on start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        base_q <= base_addr;
        cnt_q  <= word_count;
      end
    end
  end

  // Received and issued word counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt <= '0;
      wr_cnt <= '0;
    end else if (arm) begin
      rx_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (hs)  rx_cnt <= rx_cnt + CNT_ONE;
      if (pop) wr_cnt <= wr_cnt + CNT_ONE;
    end
  end

  // FIFO pointers; a new run always starts from an empty buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (arm) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (hs)  wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (hs) fifo_mem[wptr[AW-1:0]] <= ip_data;
  end

  // Registered write port: load on pop, idle to zero once accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      unique case (1'b1)
        pop: begin
          wen_q   <= 1'b1;
          waddr_q <= base_q + ADDR_W'(wr_cnt);
          wdata_q <= fifo_mem[rptr[AW-1:0]];
        end
        (wr_done && !pop): begin
          wen_q   <= 1'b0;
          waddr_q <= '0;
          wdata_q <= '0;
        end
        default: begin
          wen_q   <= wen_q;
          waddr_q <= waddr_q;
          wdata_q <= wdata_q;
        end
      endcase
    end
  end

  // Sticky flag for IP output arriving while no run is armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (arm) begin
      err <= 1'b0;
    end else if (ip_valid &&
                 ((state_q == IDLE) || (state_q == DONE))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ip_result_collector.sv
// tb_ip_result_collector: randomized scenarios checked against a
// queue-based model of ordered, address-incrementing result writes.
module tb_ip_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] base_addr;
  logic [15:0] word_count;
  logic [31:0] ip_data;
  logic        ip_valid;
  logic        ip_ready;
  logic        mem_stall;
  logic        mem_ena;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int vec = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] pend [$];
  logic [31:0] hs_d [$];
  int          hs_c [$];
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  int          dc [$];
  int          bcnt;
  int          hold_bad;
  int          idle_bad;
  logic        hold_pend;
  logic [65:0] hold_v;

  ip_result_collector #(.FIFO_DEPTH(8), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .ip_data(ip_data), .ip_valid(ip_valid),
    .ip_ready(ip_ready), .mem_stall(mem_stall),
    .mem_ena(mem_ena), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive observer: records handshakes, writes and done pulses
  always @(negedge clk) begin
    if (ip_valid && ip_ready) begin
      hs_d.push_back(ip_data);
      hs_c.push_back(cyc);
    end
    if (mem_ena && !mem_stall) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (done) dc.push_back(cyc);
    if (busy) bcnt++;
    if (!mem_ena && (mem_rw || mem_addr != 0 || mem_wdata != 0))
      idle_bad++;
    if (mem_ena && !mem_rw) idle_bad++;
    if (hold_pend &&
        {mem_ena, mem_rw, mem_addr, mem_wdata} !== hold_v)
      hold_bad++;
    hold_pend = mem_ena && mem_stall;
    hold_v = {mem_ena, mem_rw, mem_addr, mem_wdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_d.delete(); hs_c.delete();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
    bcnt = 0; hold_bad = 0; idle_bad = 0; hold_pend = 1'b0;
  endtask

  task automatic drive_run(input logic [19:0] b, input int n,
                           input int vpct, input int spct,
                           input bit inj, input int budget);
    int k;
    clear_mon();
    pend.delete();
    for (int i = 0; i < n; i++) pend.push_back($urandom);
    base_addr = b; word_count = 16'(n);
    ip_valid = 1'b0; mem_stall = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < budget && dc.size() == 0; i++) begin
      k = hs_d.size();
      ip_valid = (k < n) && ($urandom_range(99) < vpct);
      ip_data = (k < n) ? pend[k] : $urandom;
      mem_stall = ($urandom_range(99) < spct);
      start = inj && ($urandom_range(9) == 0);
      if (start) begin
        base_addr = 20'($urandom);
        word_count = 16'($urandom);
      end
      tick();
    end
    start = 1'b0; ip_valid = 1'b0; mem_stall = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; ip_valid = 1'b1;
    mem_stall = 1'b0; base_addr = 20'h12345;
    word_count = 16'd4; ip_data = 32'hdeadbeef;
    tick(); tick(); tick();
    vec++;
    if ({ip_ready, mem_ena, mem_rw, mem_addr, mem_wdata,
         busy, done, err} !== 70'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b ena=%b err=%b want all 0",
               busy, mem_ena, err);
    end
    start = 1'b0; ip_valid = 1'b0; rst = 1'b1;
    tick();
    vec++;
    if ({busy, done, err, mem_ena, ip_ready} !== 5'd0) begin
      bad++;
      $display("FAIL reset_release: got %b want 00000",
               {busy, done, err, mem_ena, ip_ready});
    end
  endtask

  task automatic test_basic();
    drive_run(20'h00100, 3, 100, 0, 0, 60);
    vec++;
    if (wa.size() != 3) begin
      bad++;
      $display("FAIL basic_count: got %0d want 3", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 3; i++) begin
      vec++;
      if (wa[i] !== 32'h100 + 32'(i) || wd[i] !== pend[i] ||
          wc[i] !== hs_c[i] + 2) begin
        bad++;
        $display("FAIL basic_write[%0d]: got a=%h d=%h t=%0d want a=%h d=%h t=%0d",
                 i, wa[i], wd[i], wc[i], 32'h100 + 32'(i),
                 pend[i], hs_c[i] + 2);
      end
    end
    vec++;
    if (dc.size() != 1 || wc.size() != 3 || dc[0] != wc[2] + 1) begin
      bad++;
      $display("FAIL basic_done: got %0d pulses want 1 pulse after last write",
               dc.size());
    end
  endtask

  task automatic test_stall();
    int k;
    clear_mon();
    pend.delete();
    for (int i = 0; i < 12; i++) pend.push_back($urandom);
    base_addr = 20'h0A000; word_count = 16'd12;
    ip_valid = 1'b0; mem_stall = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      k = hs_d.size();
      ip_valid = (k < 12);
      ip_data = (k < 12) ? pend[k] : 32'h0;
      tick();
    end
    vec++;
    if (hs_d.size() != 8 || ip_ready !== 1'b0 || wa.size() != 0) begin
      bad++;
      $display("FAIL stall_full: got acc=%0d rdy=%b wr=%0d want 8 0 0",
               hs_d.size(), ip_ready, wa.size());
    end
    mem_stall = 1'b0;
    for (int i = 0; i < 100 && dc.size() == 0; i++) begin
      k = hs_d.size();
      ip_valid = (k < 12);
      ip_data = (k < 12) ? pend[k] : 32'h0;
      tick();
    end
    ip_valid = 1'b0;
    tick();
    vec++;
    if (wa.size() != 12 || dc.size() != 1) begin
      bad++;
      $display("FAIL stall_total: got wr=%0d done=%0d want 12 1",
               wa.size(), dc.size());
    end
    for (int i = 0; i < wa.size() && i < 12; i++) begin
      vec++;
      if (wa[i] !== 32'h0A000 + 32'(i) || wd[i] !== pend[i]) begin
        bad++;
        $display("FAIL stall_write[%0d]: got a=%h d=%h want a=%h d=%h",
                 i, wa[i], wd[i], 32'h0A000 + 32'(i), pend[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] b;
    logic [19:0] ea;
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(20, 1);
      b = 20'($urandom);
      drive_run(b, n, 60, 30, 1, 2000);
      vec++;
      if (wa.size() != n || hs_d.size() != n || dc.size() != 1) begin
        bad++;
        $display("FAIL rand%0d_count: got wr=%0d acc=%0d done=%0d want %0d %0d 1",
                 r, wa.size(), hs_d.size(), dc.size(), n, n);
      end
      for (int i = 0; i < wa.size() && i < n; i++) begin
        ea = b + 20'(i);
        vec++;
        if (wa[i] !== {12'h0, ea} || wd[i] !== pend[i] ||
            wc[i] < hs_c[i] + 2) begin
          bad++;
          $display("FAIL rand%0d_write[%0d]: got a=%h d=%h want a=%h d=%h",
                   r, i, wa[i], wd[i], {12'h0, ea}, pend[i]);
        end
      end
      vec++;
      if (dc.size() != 1 || wc.size() != n || dc[0] != wc[n-1] + 1) begin
        bad++;
        $display("FAIL rand%0d_done_time: got %0d pulses want 1 after last write",
                 r, dc.size());
      end
      vec++;
      if (hold_bad != 0 || idle_bad != 0) begin
        bad++;
        $display("FAIL rand%0d_port: got hold=%0d idle=%0d want 0 0",
                 r, hold_bad, idle_bad);
      end
    end
  endtask

  task automatic test_zero();
    drive_run(20'h00055, 0, 100, 0, 0, 10);
    vec++;
    if (wa.size() != 0 || bcnt != 1 || dc.size() != 1) begin
      bad++;
      $display("FAIL zero_count: got wr=%0d busy=%0d done=%0d want 0 1 1",
               wa.size(), bcnt, dc.size());
    end
  endtask

  task automatic test_wrap();
    drive_run(20'hFFFFF, 2, 100, 0, 0, 40);
    vec++;
    if (wa.size() != 2) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 2", wa.size());
    end else begin
      vec++;
      if (wa[0] !== 32'h000FFFFF || wa[1] !== 32'h00000000) begin
        bad++;
        $display("FAIL wrap_addr: got %h %h want 000fffff 00000000",
                 wa[0], wa[1]);
      end
    end
  endtask

  task automatic test_err();
    vec++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_base: got %b want 0", err);
    end
    ip_valid = 1'b1; ip_data = 32'h1;
    tick();
    ip_valid = 1'b0;
    tick(); tick();
    vec++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set: got %b want 1", err);
    end
    drive_run(20'h00200, 1, 100, 0, 0, 40);
    vec++;
    if (err !== 1'b0 || wa.size() != 1) begin
      bad++;
      $display("FAIL err_clear: got err=%b wr=%0d want 0 1",
               err, wa.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    pend.delete();
    for (int i = 0; i < 6; i++) pend.push_back($urandom);
    base_addr = 20'h03000; word_count = 16'd6;
    ip_valid = 1'b0; mem_stall = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30 && hs_d.size() < 3; i++) begin
      k = hs_d.size();
      ip_valid = 1'b1;
      ip_data = pend[k];
      tick();
    end
    ip_valid = 1'b0;
    vec++;
    if (busy !== 1'b1 || hs_d.size() != 3) begin
      bad++;
      $display("FAIL mid_prep: got busy=%b acc=%0d want 1 3",
               busy, hs_d.size());
    end
    #2 rst = 1'b0;
    #1;
    vec++;
    if ({ip_ready, mem_ena, mem_rw, mem_addr, mem_wdata,
         busy, done, err} !== 70'd0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b ena=%b addr=%h want all 0",
               busy, mem_ena, mem_addr);
    end
    tick(); tick();
    rst = 1'b1;
    clear_mon();
    for (int i = 0; i < 15; i++) tick();
    vec++;
    if (wa.size() != 0 || bcnt != 0) begin
      bad++;
      $display("FAIL mid_after: got wr=%0d busy=%0d want 0 0",
               wa.size(), bcnt);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1; word_count = 16'd0;
    tick();
    start = 1'b0;
    vec++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL first_start: got busy=%b done=%b want 1 1",
               busy, done);
    end
    tick();
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL first_idle: got busy=%b done=%b want 0 0",
               busy, done);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    hold_pend = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_wrap();
    test_err();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
